// File: rtl/icache_pkg.sv
// Shared memory-request definitions for the instruction cache.
// Request length codes and address-split defaults.
package icache_pkg;

  localparam int DEF_INDEX_BITS  = 6;
  localparam int DEF_OFFSET_BITS = 2;

  localparam logic [2:0] LEN_BYTE = 3'b000;
  localparam logic [2:0] LEN_HALF = 3'b001;
  localparam logic [2:0] LEN_WORD = 3'b010;
  localparam int         LEN_SIGNED_BIT = 2;

  function automatic int tag_bits(input int ib, input int ob);
    return 32 - 2 - ob - ib;
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and controller-side handshake bundles of the icache.
// master drives the request, slave answers it.
interface fetch_if;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_inst;

  modport master (
    output if_valid, if_addr,
    input  if_ready, if_inst
  );
  modport slave (
    input  if_valid, if_addr,
    output if_ready, if_inst
  );
endinterface

interface mem_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [2:0]  mem_len;
  logic        mem_ready;
  logic [31:0] mem_res;

  modport master (
    output mem_valid, mem_addr, mem_len,
    input  mem_ready, mem_res
  );
  modport slave (
    input  mem_valid, mem_addr, mem_len,
    output mem_ready, mem_res
  );
endinterface

// File: rtl/icache_data_array.sv
// Tag and line storage: one synchronous write port,
// one asynchronous read port.
module icache_data_array #(
  parameter int INDEX_BITS = 6,
  parameter int WORDS      = 4,
  parameter int TAG_W      = 22
) (
  input  logic                   clk_in,
  input  logic                   we,
  input  logic [INDEX_BITS-1:0]  waddr,
  input  logic [TAG_W-1:0]       wtag,
  input  logic [WORDS-1:0][31:0] wline,
  input  logic [INDEX_BITS-1:0]  raddr,
  output logic [TAG_W-1:0]       rtag,
  output logic [WORDS-1:0][31:0] rline
);

  localparam int LINES = 2**INDEX_BITS;

  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [WORDS-1:0][31:0] line_mem [LINES];

  always_ff @(posedge clk_in) begin
    if (we) begin
      tag_mem[waddr]  <= wtag;
      line_mem[waddr] <= wline;
    end
  end

  assign rtag  = tag_mem[raddr];
  assign rline = line_mem[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with
// word-by-word line refill and abortable fetch.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic   clk_in,
  input  logic   rst_n_in,
  input  logic   rdy_in,
  input  logic   clear_in,
  fetch_if.slave fetch,
  mem_if.master  mem
);

  localparam int WORDS  = 2**OFFSET_BITS;
  localparam int LINES  = 2**INDEX_BITS;
  localparam int TAG_W  = tag_bits(INDEX_BITS, OFFSET_BITS);
  localparam int BASE_W = 30 - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FILL,
    ABORT
  } state_t;

  state_t                 state;
  logic [OFFSET_BITS-1:0] beat;
  logic [OFFSET_BITS-1:0] beat_nx;
  logic [BASE_W-1:0]      line_base;
  logic [WORDS-1:0][31:0] line_buf;
  logic [LINES-1:0]       valid;
  logic                   mem_valid_q;
  logic [31:0]            mem_addr_q;

  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off;
  logic [TAG_W-1:0]       fill_tag;
  logic [INDEX_BITS-1:0]  fill_idx;
  logic [TAG_W-1:0]       rd_tag;
  logic [WORDS-1:0][31:0] rd_line;
  logic                   hit;
  logic                   miss;
  logic                   last_beat;
  logic                   fill_we;
  logic                   if_ready;
  logic                   unused_addr;

  assign req_tag  = fetch.if_addr[31 -: TAG_W];
  assign req_idx  = fetch.if_addr[2+OFFSET_BITS +: INDEX_BITS];
  assign req_off  = fetch.if_addr[2 +: OFFSET_BITS];
  assign fill_tag = line_base[BASE_W-1 -: TAG_W];
  assign fill_idx = line_base[INDEX_BITS-1:0];
  assign unused_addr = ^fetch.if_addr[1:0];

  assign beat_nx   = beat + 1'b1;
  assign last_beat = (beat == OFFSET_BITS'(WORDS-1));
  assign fill_we   = rdy_in && (state == FILL);

  icache_data_array #(
    .INDEX_BITS (INDEX_BITS),
    .WORDS      (WORDS),
    .TAG_W      (TAG_W)
  ) u_data (
    .clk_in (clk_in),
    .we     (fill_we),
    .waddr  (fill_idx),
    .wtag   (fill_tag),
    .wline  (line_buf),
    .raddr  (req_idx),
    .rtag   (rd_tag),
    .rline  (rd_line)
  );

  assign hit = valid[req_idx] && (rd_tag == req_tag);

  // Hits answer only from IDLE so a line being filled never leaks out early.
  assign if_ready = (state == IDLE) && fetch.if_valid && hit
                  && !clear_in && rdy_in;
  assign miss = (state == IDLE) && fetch.if_valid && !hit
              && !clear_in;

  assign fetch.if_ready = if_ready;
  assign fetch.if_inst  = if_ready ? rd_line[req_off] : '0;

  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_len   = LEN_WORD;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      beat        <= '0;
      line_base   <= '0;
      line_buf    <= '0;
      valid       <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
    end else if (rdy_in) begin
      unique case (state)
        IDLE: begin
          if (miss) begin
            state       <= REFILL;
            beat        <= '0;
            line_base   <= fetch.if_addr[31 -: BASE_W];
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {fetch.if_addr[31 -: BASE_W],
                            {(OFFSET_BITS+2){1'b0}}};
          end
        end
        REFILL: begin
          if (mem.mem_ready) begin
            line_buf[beat] <= mem.mem_res;
            beat           <= beat_nx;
            if (last_beat || clear_in) begin
              mem_valid_q <= 1'b0;
              state <= (last_beat && !clear_in) ? FILL : IDLE;
            end else begin
              mem_addr_q <= {line_base, beat_nx, 2'b00};
            end
          end else if (clear_in) begin
            // The outstanding beat must still be accepted by the controller.
            state <= ABORT;
          end
        end
        FILL: begin
          valid[fill_idx] <= 1'b1;
          state           <= IDLE;
        end
        ABORT: begin
          if (mem.mem_ready) begin
            mem_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed and randomized checks of icache against a
// line-level reference model of the cache contents.
module tb_icache;
  import icache_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b0;
  logic clr   = 1'b0;

  fetch_if fif ();
  mem_if   mif ();

  icache dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .clear_in (clr),
    .fetch    (fif),
    .mem      (mif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit          vm [64];
  logic [21:0] tm [64];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h7F4A_7C15;
  endfunction

  task automatic chk(input string t, input logic [31:0] o,
                     input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", t, o, e);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] a,
                     input logic c, input logic r, input logic mr);
    @(negedge clk);
    fif.if_valid  = v;
    fif.if_addr   = a;
    clr           = c;
    rdy           = r;
    mif.mem_ready = mr;
    mif.mem_res   = mw(mif.mem_addr);
    #1;
  endtask

  // One fetch with a randomly slow controller; the model decides hit/miss.
  task automatic run_fetch(input logic [31:0] a, output logic hit);
    int          idx;
    logic [21:0] tg;
    logic        exp_hit;
    logic [31:0] base;
    int          beats;
    int          n;
    int          last;
    int          lat;
    logic        mr;
    logic        done;
    idx     = int'(a[9:4]);
    tg      = a[31:10];
    exp_hit = vm[idx] && (tm[idx] == tg);
    base    = {a[31:4], 4'b0000};
    cyc(1'b1, a, 1'b0, 1'b1, 1'b0);
    hit = fif.if_ready;
    chk("hit_flag", fif.if_ready, exp_hit);
    if (exp_hit) begin
      chk("hit_inst", fif.if_inst, mw({a[31:2], 2'b00}));
      chk("hit_nomem", mif.mem_valid, 1'b0);
    end else begin
      beats = 0;
      n     = 0;
      last  = 0;
      done  = 1'b0;
      lat   = $urandom_range(0, 2);
      while (!done && n < 100) begin
        @(negedge clk);
        mr = 1'b0;
        if (mif.mem_valid) begin
          if (lat == 0) begin
            mr  = 1'b1;
            lat = $urandom_range(0, 2);
          end else begin
            lat--;
          end
        end
        fif.if_valid  = 1'b1;
        fif.if_addr   = a;
        clr           = 1'b0;
        rdy           = 1'b1;
        mif.mem_ready = mr;
        mif.mem_res   = mw(mif.mem_addr);
        #1;
        n++;
        if (mr) begin
          chk("beat_addr", mif.mem_addr, base + 32'(beats * 4));
          chk("beat_len", 32'(mif.mem_len), 32'(LEN_WORD));
          beats++;
          last = n;
        end
        if (fif.if_ready) begin
          done = 1'b1;
          chk("miss_lat", 32'(n - last), 32'd2);
          chk("miss_beats", 32'(beats), 32'd4);
          chk("miss_inst", fif.if_inst, mw({a[31:2], 2'b00}));
        end
      end
      if (!done) chk("miss_timeout", 32'(n), 32'd0);
      vm[idx] = 1'b1;
      tm[idx] = tg;
    end
  endtask

  initial begin
    logic        h;
    logic [31:0] a;
    fif.if_valid  = 1'b0;
    fif.if_addr   = '0;
    mif.mem_ready = 1'b0;
    mif.mem_res   = '0;
    foreach (vm[i]) vm[i] = 1'b0;

    // reset
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mvalid", mif.mem_valid, 1'b0);
    chk("rst_ready", fif.if_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("rst_maddr", mif.mem_addr, 32'h0);
    chk("rst_inst", fif.if_inst, 32'h0);
    chk("rst_mvalid2", mif.mem_valid, 1'b0);

    // cold miss then same-line hit
    run_fetch(32'h0000_0000, h);
    chk("t1_miss", h, 1'b0);
    run_fetch(32'h0000_0008, h);
    chk("t1_hit", h, 1'b1);

    // conflict on index 0
    run_fetch(32'h0000_0400, h);
    chk("t2_miss400", h, 1'b0);
    run_fetch(32'h0000_0000, h);
    chk("t2_miss000", h, 1'b0);

    // clear while beat 1 outstanding
    a = 32'h0000_0040;
    cyc(1'b1, a, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, a, 1'b0, 1'b1, 1'b1);
    chk("t3_b0", mif.mem_addr, a);
    cyc(1'b0, a, 1'b1, 1'b1, 1'b0);
    chk("t3_clr_addr", mif.mem_addr, a + 32'd4);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, a, 1'b0, 1'b1, 1'b0);
      chk("t3_hold_v", mif.mem_valid, 1'b1);
      chk("t3_hold_a", mif.mem_addr, a + 32'd4);
    end
    cyc(1'b0, a, 1'b0, 1'b1, 1'b1);
    chk("t3_last_v", mif.mem_valid, 1'b1);
    cyc(1'b0, a, 1'b0, 1'b1, 1'b0);
    chk("t3_drop_v", mif.mem_valid, 1'b0);
    chk("t3_noready", fif.if_ready, 1'b0);
    run_fetch(a, h);
    chk("t3_refetch", h, 1'b0);

    // clear with final beat
    a = 32'h0000_0080;
    cyc(1'b1, a, 1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 3; b++) begin
      cyc(1'b1, a, 1'b0, 1'b1, 1'b1);
      chk("t4_addr", mif.mem_addr, a + 32'(b * 4));
    end
    cyc(1'b0, a, 1'b1, 1'b1, 1'b1);
    chk("t4_addr3", mif.mem_addr, a + 32'd12);
    cyc(1'b0, a, 1'b0, 1'b1, 1'b0);
    chk("t4_drop_v", mif.mem_valid, 1'b0);
    chk("t4_noready", fif.if_ready, 1'b0);
    run_fetch(a, h);
    chk("t4_refetch", h, 1'b0);

    // rdy_in low mid-refill
    a = 32'h0000_00C0;
    cyc(1'b1, a, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, a, 1'b0, 1'b1, 1'b1);
    chk("t5_b0", mif.mem_addr, a);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, a, 1'b0, 1'b0, 1'b0);
      chk("t5_frz_v", mif.mem_valid, 1'b1);
      chk("t5_frz_a", mif.mem_addr, a + 32'd4);
      chk("t5_frz_r", fif.if_ready, 1'b0);
    end
    for (int b = 1; b < 4; b++) begin
      cyc(1'b1, a, 1'b0, 1'b1, 1'b1);
      chk("t5_addr", mif.mem_addr, a + 32'(b * 4));
    end
    cyc(1'b1, a, 1'b0, 1'b1, 1'b0);
    chk("t5_fill_r", fif.if_ready, 1'b0);
    cyc(1'b1, a, 1'b0, 1'b0, 1'b0);
    chk("t5_rdylow_r", fif.if_ready, 1'b0);
    cyc(1'b1, a, 1'b0, 1'b1, 1'b0);
    chk("t5_hit_r", fif.if_ready, 1'b1);
    chk("t5_hit_i", fif.if_inst, mw(a));
    vm[12] = 1'b1;
    tm[12] = '0;

    // asynchronous reset mid-refill
    a = 32'h0000_0100;
    cyc(1'b1, a, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, a, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, a, 1'b0, 1'b1, 1'b0);
    chk("t6_pre_v", mif.mem_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_v", mif.mem_valid, 1'b0);
    chk("t6_rst_a", mif.mem_addr, 32'h0);
    fif.if_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (vm[i]) vm[i] = 1'b0;
    run_fetch(32'h0000_0000, h);
    chk("t6_miss0", h, 1'b0);
    run_fetch(32'h0000_00C0, h);
    chk("t6_missC0", h, 1'b0);
    run_fetch(32'h0000_0400, h);
    chk("t6_miss400", h, 1'b0);

    // random fetches over a small conflicting footprint
    for (int k = 0; k < 40; k++) begin
      a = (32'($urandom_range(0, 1)) << 10)
        | (32'($urandom_range(0, 7)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      run_fetch(a, h);
    end

    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
